dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the core's load/store port. It accepts one request at a time over a valid/ready handshake and performs byte, halfword and word accesses with RV32I funct3 semantics. It adds configurable wait states and returns read data or an error over a second valid/ready handshake. It replaces the bare single-port data RAM when the core moves to a stall-capable memory interface.

## Interface
- ADDR_WIDTH, 32, request address width (byte address)
- DATA_WIDTH, 32, data width; only 32 is supported
- MEM_ADDR_BITS, 9, log2 of the number of 32-bit words stored
- WAIT_CYCLES, 1, extra cycles in BUSY before the memory access (0..15)
- BASE_ADDR, 0, byte address mapped to word 0; must be 4-byte aligned
- clk  in  1  clock; reset Reset, synchronous, active-high; clock clk
- Reset  in  1  synchronous active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  responder can accept a request
- ReqWe  in  1  1 = store, 0 = load
- ReqAddr  in  ADDR_WIDTH  byte address
- ReqFunct3  in  3  RV32I load/store funct3
- ReqWdata  in  DATA_WIDTH  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- RspValid  out  1  response present
- RspReady  in  1  core accepts the response
- RspRdata  out  DATA_WIDTH  load result, extended per funct3; 0 for stores and errors
- RspErr  out  1  misaligned, out-of-range or illegal funct3

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: ReqReady=1. On ReqValid, capture We, Addr, Funct3 and Wdata, load WaitCnt=WAIT_CYCLES, and go to BUSY.
- BUSY: ReqReady=0.
  - If WaitCnt!=0, decrement it.
  - Otherwise, evaluate the error check and issue the RAM access, then go to RESP.
- RESP: RspValid=1. RspRdata and RspErr stay stable until RspReady=1. On RspReady=1, go to IDLE.
- Offset = Addr - BASE_ADDR (ADDR_WIDTH-bit unsigned). Word index = Offset[MEM_ADDR_BITS+1:2]. Lane = Offset[1:0].
- Error conditions (any one sets RspErr):
  - Out of range: Offset >= 4<<MEM_ADDR_BITS.
  - Misaligned: H/HU with Lane[0]=1, or W with Lane!=0.
  - Illegal funct3: loads 3, 6, 7; stores >= 3.
- On error: no RAM write, RspRdata=0, RspErr=1.
- Loads:
  - LB/LBU select byte Lane and sign-/zero-extend it.
  - LH/LHU select halfword Lane[1] and sign-/zero-extend it.
  - LW returns the whole word.
- Stores:
  - Byte-enable write: SB sets one lane, SH sets two lanes, SW sets all four.
  - Data is replicated across lanes.
  - RspRdata=0, RspErr=0.
- Memory contents are not affected by Reset.

## Timing
- Reset values: state IDLE, ReqReady=1, RspValid=0, RspRdata=0, RspErr=0, WaitCnt=0.
- Request accepted at the clock edge ending cycle 0. BUSY spans cycles 1..WAIT_CYCLES+1. RspValid is first high in cycle WAIT_CYCLES+2.
- The RAM is synchronous. The read is issued in the last BUSY cycle, and RspRdata is registered into RESP.
- A store writes the RAM at the edge ending the last BUSY cycle.
- Maximum throughput is one request per WAIT_CYCLES+3 cycles. ReqReady is low in BUSY and RESP; requests held during those states are not captured.
- ReqValid is ignored while Reset=1.
- Reset asserted in BUSY before the access edge: the store is not committed. Reset asserted in RESP: the pending response is dropped, RspValid=0 in the next cycle.
- RspReady held low: the FSM stays in RESP indefinitely with outputs frozen.

## Structure
- Rv32iPkg gains:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - enum DmemStateT {IDLE, BUSY, RESP}.
  - Function DmemMisaligned(funct3, lane).
- One sub-module, dmem_bank_ram: a single-port, 4-lane byte-enable synchronous RAM (2**MEM_ADDR_BITS x 32) with optional hex init file.
- Lane decode, extension, error check and the FSM stay in dmem_responder.

## Test plan
- WAIT_CYCLES=1. SW 0xDEADBEEF to addr 0x10, then LW 0x10. Required: RspValid 3 cycles after each accept, RspRdata=0xDEADBEEF, RspErr=0.
- Memory word 0x10 = 0x8081_7F80:
  - LB 0x10 -> 0xFFFFFF80
  - LBU 0x11 -> 0x0000007F
  - LH 0x12 -> 0xFFFF8081
  - LHU 0x12 -> 0x00008081
- SB 0xAA to 0x13 over 0x11223344, then LW 0x10. Required: 0xAA223344.
- LW 0x12, SH 0x11, and LW at 0x800 (MEM_ADDR_BITS=9). Required: RspErr=1 and RspRdata=0 for each; memory unchanged.
- RspReady held low 5 cycles in RESP with ReqValid high throughout. Required: RspRdata and RspErr stable, ReqReady=0, and the second request accepted only in the cycle after the RspReady handshake.
- Reset pulsed during BUSY of SW 0x55 to 0x20 (old value 0x0). Required: RspValid never asserts, ReqReady=1 after reset, and LW 0x20 returns 0x0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared RV32I load/store definitions for the data-memory responder.
// Holds the funct3 encodings, the responder FSM states and the alignment helper.
package dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } DmemStateT;

    // Loads and stores share the size encoding in funct3[1:0].
    function automatic logic DmemMisaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic w_mis;
        case (funct3[1:0])
            2'b01:   w_mis = lane[0];
            2'b10:   w_mis = (lane != 2'b00);
            default: w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

    function automatic logic DmemIllegalF3(input logic we, input logic [2:0] funct3);
        logic w_ill;
        if (we) begin
            w_ill = (funct3 >= 3'd3);
        end else begin
            w_ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        return w_ill;
    endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// Single-port synchronous RAM, 2**ADDR_BITS words of 32 bits, with four byte-lane enables.
// Read data is registered and only updates on an enabled read.
module dmem_bank_ram #(
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [3:0]           i_be,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [2**ADDR_BITS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the RV32I load/store port: valid/ready request and response,
// configurable wait states, byte/halfword/word accesses and error reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           MEM_ADDR_BITS = 9,
    parameter int unsigned           WAIT_CYCLES   = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWe,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [2:0]            ReqFunct3,
    input  logic [DATA_WIDTH-1:0] ReqWdata,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [DATA_WIDTH-1:0] RspRdata,
    output logic                  RspErr
);

    DmemStateT             r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wait_cnt;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_rsp_load;

    logic [ADDR_WIDTH-1:0]    w_offset;
    logic [1:0]               w_lane;
    logic [MEM_ADDR_BITS-1:0] w_word;
    logic                     w_err;
    logic                     w_access;
    logic                     w_ram_en;
    logic [3:0]               w_be;
    logic [31:0]              w_ram_wdata;
    logic [31:0]              w_ram_rdata;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [31:0]              w_load_data;

    assign w_offset = r_addr - BASE_ADDR;
    assign w_lane   = w_offset[1:0];
    assign w_word   = w_offset[MEM_ADDR_BITS+1:2];

    assign w_err = (|w_offset[ADDR_WIDTH-1:MEM_ADDR_BITS+2])
                 || DmemMisaligned(r_funct3, w_lane)
                 || DmemIllegalF3(r_we, r_funct3);

    assign w_access = (r_state == BUSY) && (r_wait_cnt == 4'd0);
    // Reset at the access edge must cancel the store as well as the FSM transition.
    assign w_ram_en = w_access && !w_err && !Reset;

    always_comb begin
        w_be        = 4'b1111;
        w_ram_wdata = r_wdata;
        case (r_funct3)
            F3_SB: begin
                w_be        = 4'b0001 << w_lane;
                w_ram_wdata = {4{r_wdata[7:0]}};
            end
            F3_SH: begin
                w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
                w_ram_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_ram_wdata = r_wdata;
            end
        endcase
    end

    dmem_bank_ram #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (r_we),
        .i_be    (w_be),
        .i_addr  (w_word),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM output and the captured lane/funct3 are held through RESP, so this stays stable.
    assign w_byte = w_ram_rdata[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];

    always_comb begin
        w_load_data = w_ram_rdata;
        case (r_funct3)
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_load_data = {24'd0, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_wait_cnt  <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        r_we       <= ReqWe;
                        r_addr     <= ReqAddr;
                        r_funct3   <= ReqFunct3;
                        r_wdata    <= ReqWdata[31:0];
                        r_wait_cnt <= 4'(WAIT_CYCLES);
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_load  <= !w_err && !r_we;
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_load  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_load  <= 1'b0;
                end
            endcase
        end
    end

    assign ReqReady = (r_state == IDLE);
    assign RspValid = r_rsp_valid;
    assign RspErr   = r_rsp_err;
    assign RspRdata = r_rsp_load ? DATA_WIDTH'(w_load_data) : '0;

endmodule
